tx_ctrl_sys: RTL and testbench

TX_CTRL_SYS -- requirements
Module: tx_ctrl_sys

---
 rtl/tx_ctrl_sys.sv | 146 ++++++++++++++
 tb/tb_tx_ctrl_sys.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_ctrl_sys.sv
// Response-to-UART transmit controller: frames RF (1 byte) and ALU (2 byte) responses and
// hands them byte by byte to the UART transmitter using a BUSY handshake.
module tx_ctrl_sys #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  RD_DATA_VLD,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CTRL_BUSY,
  output logic                  OVERRUN
);

  localparam int FW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state;
  logic [FW-1:0]         frame_buf;
  logic                  frame_two;
  logic                  byte_idx;
  logic                  pend_vld;
  logic                  pend_alu;
  logic [FW-1:0]         pend_data;

  logic [FW-1:0]         rd_ext;
  logic [FW-1:0]         alu_ext;
  logic [DATA_WIDTH-1:0] cur_byte;
  logic                  in_frame;

  assign rd_ext   = FW'(RD_DATA);
  assign alu_ext  = FW'(ALU_OUT);
  assign cur_byte = byte_idx ? frame_buf[FW-1:DATA_WIDTH] : frame_buf[DATA_WIDTH-1:0];
  assign in_frame = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      frame_buf <= '0;
      frame_two <= 1'b0;
      byte_idx  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_alu  <= 1'b0;
      pend_data <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CTRL_BUSY <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      TX_D_VLD <= 1'b0;
      OVERRUN  <= 1'b0;
      case (state)
        IDLE: begin
          CTRL_BUSY <= pend_vld | RD_DATA_VLD | ALU_OUT_VLD;
          byte_idx  <= 1'b0;
          if (pend_vld) begin
            // Slot drains into the frame buffer; one new input may refill it this cycle.
            frame_buf <= pend_data;
            frame_two <= pend_alu;
            state     <= SEND;
            if (RD_DATA_VLD) begin
              pend_alu  <= 1'b0;
              pend_data <= rd_ext;
              OVERRUN   <= ALU_OUT_VLD;
            end else if (ALU_OUT_VLD) begin
              pend_alu  <= 1'b1;
              pend_data <= alu_ext;
            end else begin
              pend_vld  <= 1'b0;
              pend_alu  <= 1'b0;
              pend_data <= '0;
            end
          end else if (RD_DATA_VLD) begin
            frame_buf <= rd_ext;
            frame_two <= 1'b0;
            state     <= SEND;
            if (ALU_OUT_VLD) begin
              pend_vld  <= 1'b1;
              pend_alu  <= 1'b1;
              pend_data <= alu_ext;
            end
          end else if (ALU_OUT_VLD) begin
            frame_buf <= alu_ext;
            frame_two <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= cur_byte;
            TX_D_VLD  <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (TX_BUSY) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            if (frame_two && !byte_idx) begin
              byte_idx <= 1'b1;
              state    <= SEND;
            end else begin
              state     <= IDLE;
              CTRL_BUSY <= pend_vld | RD_DATA_VLD | ALU_OUT_VLD;
            end
          end
        end
        default: begin
          state     <= IDLE;
          frame_buf <= '0;
          frame_two <= 1'b0;
          byte_idx  <= 1'b0;
          pend_vld  <= 1'b0;
          pend_alu  <= 1'b0;
          pend_data <= '0;
          TX_P_DATA <= '0;
          CTRL_BUSY <= 1'b0;
        end
      endcase

      // Responses arriving mid-frame go to the slot; a full slot drops them.
      if (in_frame) begin
        if (pend_vld) begin
          OVERRUN <= RD_DATA_VLD | ALU_OUT_VLD;
        end else if (RD_DATA_VLD) begin
          pend_vld  <= 1'b1;
          pend_alu  <= 1'b0;
          pend_data <= rd_ext;
          OVERRUN   <= ALU_OUT_VLD;
        end else if (ALU_OUT_VLD) begin
          pend_vld  <= 1'b1;
          pend_alu  <= 1'b1;
          pend_data <= alu_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_ctrl_sys.sv
// Scoreboard bench for tx_ctrl_sys: directed responses push expected bytes, a monitor pops
// and compares on every TX_D_VLD pulse; a small UART model answers with a BUSY window.
module tb_tx_ctrl_sys;

  localparam int BUSY_CYC = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RD_DATA = '0;
  logic        RD_DATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        CTRL_BUSY;
  logic        OVERRUN;

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  assign TX_BUSY = model_busy | force_busy;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ov_seen = 0;
  int   exp_ov = 0;

  tx_ctrl_sys #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RD_DATA     (RD_DATA),
    .RD_DATA_VLD (RD_DATA_VLD),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_BUSY     (TX_BUSY),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .CTRL_BUSY   (CTRL_BUSY),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // UART model: a load request opens a BUSY window.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && TX_D_VLD) begin
        model_busy = 1'b1;
        repeat (BUSY_CYC) @(negedge CLK);
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: every load request is matched against the head of the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      if (OVERRUN) ov_seen++;
      if (TX_D_VLD) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_tx: got byte 0x%0h, required no pulse (cycle %0d)",
                   TX_P_DATA, cyc);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'd0, TX_P_DATA}, {24'd0, e.data});
          if (e.due >= 0) check("tx_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rv, input logic [7:0] rd, input logic av,
                       input logic [15:0] ad, output int t);
    @(negedge CLK);
    RD_DATA     = rd;
    RD_DATA_VLD = rv;
    ALU_OUT     = ad;
    ALU_OUT_VLD = av;
    t           = cyc;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 300 && (CTRL_BUSY || TX_BUSY || exp_q.size() != 0)) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_ctrl_busy"}, {31'd0, CTRL_BUSY}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_overrun_cnt"}, ov_seen, exp_ov);
  endtask

  initial begin
    int t;
    int m;
    repeat (3) @(negedge CLK);
    check("rst_tx_p_data", {24'd0, TX_P_DATA}, 32'd0);
    check("rst_tx_d_vld", {31'd0, TX_D_VLD}, 32'd0);
    check("rst_ctrl_busy", {31'd0, CTRL_BUSY}, 32'd0);
    check("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single RF byte with 2-cycle latency.
    drive(1'b1, 8'h5A, 1'b0, 16'h0, t);
    push(8'h5A, t + 2);
    check("rf_ctrl_busy", {31'd0, CTRL_BUSY}, 32'd1);
    wait_idle("rf");

    // ALU response: low byte then high byte.
    drive(1'b0, 8'h00, 1'b1, 16'h1234, t);
    push(8'h34, t + 2);
    push(8'h12, -1);
    wait_idle("alu");

    // Simultaneous RF and ALU: RF first, ALU from the slot, no overrun.
    drive(1'b1, 8'h0F, 1'b1, 16'hBEEF, t);
    push(8'h0F, t + 2);
    push(8'hEF, -1);
    push(8'hBE, -1);
    wait_idle("simul");

    // Mid-frame: first RF queued, second dropped with one OVERRUN pulse.
    drive(1'b0, 8'h00, 1'b1, 16'hCAFE, t);
    push(8'hFE, t + 2);
    push(8'hCA, -1);
    drive(1'b1, 8'h01, 1'b0, 16'h0, t);
    push(8'h01, -1);
    drive(1'b1, 8'h02, 1'b0, 16'h0, t);
    exp_ov++;
    wait_idle("overrun");

    // TX_BUSY held at SEND: no pulse until one cycle after it falls.
    force_busy = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 16'h0, t);
    repeat (18) @(negedge CLK);
    check("hold_ctrl_busy", {31'd0, CTRL_BUSY}, 32'd1);
    force_busy = 1'b0;
    m = cyc;
    push(8'h77, m + 1);
    wait_idle("hold");

    // Reset during WAIT_DONE of the first ALU byte abandons the second byte.
    drive(1'b0, 8'h00, 1'b1, 16'h5678, t);
    push(8'h78, t + 2);
    m = 0;
    while (m < 50 && exp_q.size() != 0) begin
      @(negedge CLK);
      m++;
    end
    check("pre_reset_first_byte", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);
    check("pre_reset_busy", {31'd0, CTRL_BUSY}, 32'd1);
    RST = 1'b0;
    #1;
    check("async_rst_tx_p_data", {24'd0, TX_P_DATA}, 32'd0);
    check("async_rst_tx_d_vld", {31'd0, TX_D_VLD}, 32'd0);
    check("async_rst_ctrl_busy", {31'd0, CTRL_BUSY}, 32'd0);
    check("async_rst_overrun", {31'd0, OVERRUN}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    check("post_reset_idle", {31'd0, CTRL_BUSY}, 32'd0);
    drive(1'b1, 8'hA5, 1'b0, 16'h0, t);
    push(8'hA5, t + 2);
    wait_idle("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
